// File: rtl/led_fade_driver.sv
// PWM LED driver that ramps each channel's duty linearly toward its on/off request.
// Latency: request to first duty step 1..PRESCALE clk, duty to led_out 1 clk; no backpressure.
module led_fade_driver #(
  parameter int NUM_LEDS   = 4,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 1000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_req,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int PC_BITS = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PC_BITS-1:0] PRESC_LAST = PC_BITS'(PRESCALE - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PC_BITS-1:0]  presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0] duty_q [NUM_LEDS];
  logic [PWM_BITS-1:0] duty_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_out_q, led_out_d;
  logic [NUM_LEDS-1:0] ch_busy;
  logic                tick;

  always_comb begin
    tick        = (presc_cnt_q == PRESC_LAST);
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      duty_d[i] = duty_q[i];
      if (tick) begin
        if (led_req[i] && (duty_q[i] != MAX)) begin
          duty_d[i] = duty_q[i] + 1'b1;
        end else if (!led_req[i] && (duty_q[i] != '0)) begin
          duty_d[i] = duty_q[i] - 1'b1;
        end
      end
      // Full scale is forced on so the pin never blips low at the counter wrap.
      led_out_d[i] = ((duty_q[i] == MAX) || (duty_q[i] > pwm_cnt_q)) ^ ACTIVE_LOW;
      ch_busy[i]   = led_req[i] ? (duty_q[i] != MAX) : (duty_q[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q   <= '0;
      presc_cnt_q <= '0;
      led_out_q   <= {NUM_LEDS{ACTIVE_LOW}};
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      presc_cnt_q <= presc_cnt_d;
      led_out_q   <= led_out_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign led_out = led_out_q;
  // Gated by reset so busy reads idle while the block is held in reset.
  assign busy    = reset_n & (|ch_busy);

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: three instances cover fast ramp, period-aligned PWM and active-low pins.
module tb_led_fade_driver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req_a = 4'b0000, req_b = 4'b0000, req_c = 4'b0000;
  logic [3:0] led_a, led_b, led_c;
  logic       busy_a, busy_b, busy_c;
  int         passed = 0;
  int         total = 0;

  typedef struct {
    logic [3:0]  req;
    int          cycles;
    logic [15:0] duty;
    logic        busy;
    logic [3:0]  led_mask;
    logic [3:0]  led;
  } vec_t;

  typedef struct {
    logic [15:0] duty;
    logic        busy;
    logic [3:0]  led_mask;
    logic [3:0]  led;
  } exp_t;

  exp_t sb[$];
  int   cnt_sb[$];

  always #5 clk = ~clk;

  led_fade_driver #(.NUM_LEDS(4), .PWM_BITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .led_req(req_a), .led_out(led_a), .busy(busy_a)
  );
  led_fade_driver #(.NUM_LEDS(4), .PWM_BITS(4), .PRESCALE(16), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .led_req(req_b), .led_out(led_b), .busy(busy_b)
  );
  led_fade_driver #(.NUM_LEDS(4), .PWM_BITS(4), .PRESCALE(4), .ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .reset_n(reset_n), .led_req(req_c), .led_out(led_c), .busy(busy_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] duties_a();
    return {dut_a.duty_q[3], dut_a.duty_q[2], dut_a.duty_q[1], dut_a.duty_q[0]};
  endfunction

  function automatic logic [15:0] duties_c();
    return {dut_c.duty_q[3], dut_c.duty_q[2], dut_c.duty_q[1], dut_c.duty_q[0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves time at the negedge where reset was released, zero rising edges since.
  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[12];
    exp_t e;
    int   bad;
    int   cnt;
    int   exp_d;

    // Edge counts in comments are rising edges since reset release; ticks land on multiples of 4.
    tbl[0]  = '{4'b0001,  3, 16'h0000, 1'b1, 4'b1110, 4'b0000}; // edge 3
    tbl[1]  = '{4'b0001,  1, 16'h0001, 1'b1, 4'b1110, 4'b0000}; // edge 4
    tbl[2]  = '{4'b0001,  4, 16'h0002, 1'b1, 4'b1110, 4'b0000}; // edge 8
    tbl[3]  = '{4'b0001, 28, 16'h0009, 1'b1, 4'b1110, 4'b0000}; // edge 36
    tbl[4]  = '{4'b0001, 23, 16'h000E, 1'b1, 4'b1110, 4'b0000}; // edge 59
    tbl[5]  = '{4'b0001,  1, 16'h000F, 1'b0, 4'b1110, 4'b0000}; // edge 60
    tbl[6]  = '{4'b0001,  1, 16'h000F, 1'b0, 4'b1111, 4'b0001}; // edge 61
    tbl[7]  = '{4'b1110,  0, 16'h000F, 1'b1, 4'b1111, 4'b0001}; // flip, busy rises at once
    tbl[8]  = '{4'b1110,  3, 16'h111E, 1'b1, 4'b0000, 4'b0000}; // edge 64
    tbl[9]  = '{4'b1110, 55, 16'hEEE1, 1'b1, 4'b0000, 4'b0000}; // edge 119
    tbl[10] = '{4'b1110,  1, 16'hFFF0, 1'b0, 4'b0000, 4'b0000}; // edge 120
    tbl[11] = '{4'b1110,  1, 16'hFFF0, 1'b0, 4'b1111, 4'b1110}; // edge 121

    // Ramp up, saturate, then opposite directions on the same ticks.
    req_a = 4'b0001;
    reset_pulse();
    foreach (tbl[i]) begin
      req_a = tbl[i].req;
      sb.push_back('{tbl[i].duty, tbl[i].busy, tbl[i].led_mask, tbl[i].led});
      cyc(tbl[i].cycles);
      #1;
      e = sb.pop_front();
      check($sformatf("tbl%0d duty", i), {16'h0, duties_a()}, {16'h0, e.duty});
      check($sformatf("tbl%0d busy", i), {31'h0, busy_a}, {31'h0, e.busy});
      check($sformatf("tbl%0d led", i), {28'h0, led_a & e.led_mask}, {28'h0, e.led});
    end

    // Saturated channel holds a constant high.
    req_a = 4'b0001;
    reset_pulse();
    cyc(61);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (led_a !== 4'b0001) bad++;
    end
    check("sat_hold_glitches", bad, 0);

    // Asynchronous reset mid-ramp, then restart from zero.
    req_a = 4'b1111;
    req_c = 4'b0000;
    reset_pulse();
    cyc(30);
    check("pre_reset_duty0", {28'h0, dut_a.duty_q[0]}, 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_led", {28'h0, led_a}, 32'h0);
    check("async_rst_busy", {31'h0, busy_a}, 32'h0);
    check("async_rst_duty", {16'h0, duties_a()}, 32'h0);
    check("async_rst_led_al", {28'h0, led_c}, 32'hF);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_busy", {31'h0, busy_a}, 32'h1);
    cyc(3);
    check("post_rst_duty_edge3", {16'h0, duties_a()}, 32'h0);
    cyc(1);
    check("post_rst_duty_edge4", {16'h0, duties_a()}, 32'h1111);

    // Reversal mid-ramp steps down one count per tick.
    req_a = 4'b0100;
    reset_pulse();
    cyc(20);
    check("rev_peak", {16'h0, duties_a()}, 32'h0500);
    req_a = 4'b0000;
    for (int c = 1; c <= 20; c++) begin
      cyc(1);
      exp_d = 5 - c / 4;
      check($sformatf("rev_duty_c%0d", c), {28'h0, dut_a.duty_q[2]}, exp_d);
      check($sformatf("rev_busy_c%0d", c), {31'h0, busy_a}, (exp_d != 0) ? 32'h1 : 32'h0);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (led_a[2] !== 1'b0) bad++;
    end
    check("rev_led2_off", bad, 0);

    // PWM period k shows exactly k high cycles when ticks line up with the counter wrap.
    req_b = 4'b0010;
    reset_pulse();
    bad = 0;
    for (int k = 0; k <= 16; k++) begin
      cnt_sb.push_back((k >= 15) ? 16 : k);
      cnt = 0;
      for (int j = 0; j < 16; j++) begin
        cyc(1);
        if (led_b[1] === 1'b1) cnt++;
        if ((led_b & 4'b1101) !== 4'b0000) bad++;
      end
      check($sformatf("pwm_period%0d_high", k), cnt, cnt_sb.pop_front());
    end
    check("pwm_other_ch_off", bad, 0);

    // Active-low pins: idle high, saturated channel constant low.
    req_c = 4'b0000;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("al_rst_led", {28'h0, led_c}, 32'hF);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(10);
    check("al_idle_led", {28'h0, led_c}, 32'hF);
    check("al_idle_busy", {31'h0, busy_c}, 32'h0);
    req_c = 4'b0001;
    cyc(57);
    check("al_busy_edge67", {31'h0, busy_c}, 32'h1);
    cyc(1);
    check("al_busy_edge68", {31'h0, busy_c}, 32'h0);
    check("al_duty_edge68", {16'h0, duties_c()}, 32'h000F);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (led_c !== 4'b1110) bad++;
    end
    check("al_sat_hold", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
